// File: rtl/wwm_projectile_ctrl.sv
// Projectile flight sequencer: launches on start, steps the center once per
// physics tick under gravity, and parks in DONE until the game FSM acks.
module wwm_projectile_ctrl #(
  parameter int TICK_DIV  = 1666667,
  parameter int X0        = 100,
  parameter int Y0        = 400,
  parameter int X_MAX     = 639,
  parameter int Y_GROUND  = 440,
  parameter int GRAVITY   = 1,
  parameter int MAX_TICKS = 1023
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       Ack,
  input  logic [3:0] vX,
  input  logic [3:0] vY,
  output logic [9:0] projectileCenterX,
  output logic [9:0] projectileCenterY,
  output logic       active,
  output logic       busy,
  output logic       done,
  output logic [1:0] result
);

  localparam int DW = $clog2(TICK_DIV + 1);
  localparam int TW = $clog2(MAX_TICKS + 1);
  localparam logic signed [11:0] YG = 12'(Y_GROUND);

  typedef enum logic [1:0] {
    IDLE,
    FLIGHT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0]      div_q;
  logic [TW-1:0]      ticks_q;
  logic [3:0]         vx_q;
  logic signed [7:0]  vely_q;
  logic [9:0]         x_q;
  logic signed [11:0] y_q;
  logic [1:0]         res_q;

  logic               tick;
  logic               launch;
  logic [10:0]        x_n;
  logic signed [11:0] y_n;
  logic signed [8:0]  vel_dec;
  logic               hit_gnd;
  logic               hit_edge;
  logic               hit_to;
  logic               fin;

  assign launch   = (state_q == IDLE) && start;
  assign tick     = (state_q == FLIGHT) &&
                    (div_q == DW'(TICK_DIV - 1));
  assign x_n      = {1'b0, x_q} + {7'd0, vx_q};
  assign y_n      = y_q - {{4{vely_q[7]}}, vely_q};
  assign vel_dec  = {vely_q[7], vely_q} - 9'(GRAVITY);
  assign hit_gnd  = y_n >= YG;
  assign hit_edge = x_n > 11'(X_MAX);
  assign hit_to   = ticks_q == TW'(MAX_TICKS - 1);
  assign fin      = tick && (hit_gnd || hit_edge || hit_to);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FLIGHT;
      FLIGHT:  if (fin)   state_d = DONE;
      DONE:    if (Ack)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    active = 1'b0;
    unique case (state_q)
      FLIGHT: begin
        busy   = 1'b1;
        active = ~y_q[11];
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        active = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      div_q   <= '0;
      ticks_q <= '0;
      vx_q    <= '0;
      vely_q  <= '0;
      x_q     <= 10'(X0);
      y_q     <= 12'(Y0);
      res_q   <= 2'b00;
    end else if (launch) begin
      div_q   <= '0;
      ticks_q <= '0;
      vx_q    <= vX;
      vely_q  <= {4'd0, vY};
      x_q     <= 10'(X0);
      y_q     <= 12'(Y0);
      res_q   <= 2'b00;
    end else if (state_q == FLIGHT) begin
      div_q <= tick ? '0 : div_q + DW'(1);
      if (tick) begin
        ticks_q <= ticks_q + TW'(1);
        // velocity floor keeps a long fall from wrapping positive
        vely_q  <= (vel_dec < -9'sd128) ? 8'sh80 : vel_dec[7:0];
        if (hit_gnd) begin
          y_q   <= YG;
          x_q   <= hit_edge ? 10'(X_MAX) : x_n[9:0];
          res_q <= 2'b01;
        end else if (hit_edge) begin
          x_q   <= 10'(X_MAX);
          y_q   <= y_n;
          res_q <= 2'b10;
        end else begin
          x_q   <= x_n[9:0];
          y_q   <= y_n;
          if (hit_to) res_q <= 2'b11;
        end
      end
    end
  end

  assign projectileCenterX = x_q;
  assign projectileCenterY = y_q[11] ? 10'd0 : y_q[9:0];
  assign result            = res_q;

endmodule

// File: tb/tb_wwm_projectile_ctrl.sv
// Bench for wwm_projectile_ctrl: four instances with different limits,
// checked tick by tick against a closed-form ballistic model.
module tb_wwm_projectile_ctrl;

  localparam int TD = 4;
  localparam int X0 = 100;
  localparam int YG = 440;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Ack = 1'b0;
  logic [3:0] vX = '0;
  logic [3:0] vY = '0;
  logic       st   [4];
  logic [9:0] px   [4];
  logic [9:0] py   [4];
  logic       act  [4];
  logic       bsy  [4];
  logic       dn   [4];
  logic [1:0] res  [4];

  int xmax_a [4] = '{639, 200, 639, 639};
  int maxt_a [4] = '{1023, 1023, 8, 1023};
  int y0_a   [4] = '{400, 400, 400, 20};

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wwm_projectile_ctrl #(.TICK_DIV(TD)) u_main (
    .clk(clk), .Reset(Reset), .start(st[0]), .Ack(Ack),
    .vX(vX), .vY(vY),
    .projectileCenterX(px[0]), .projectileCenterY(py[0]),
    .active(act[0]), .busy(bsy[0]), .done(dn[0]),
    .result(res[0]));

  wwm_projectile_ctrl #(.TICK_DIV(TD), .X_MAX(200)) u_edge (
    .clk(clk), .Reset(Reset), .start(st[1]), .Ack(Ack),
    .vX(vX), .vY(vY),
    .projectileCenterX(px[1]), .projectileCenterY(py[1]),
    .active(act[1]), .busy(bsy[1]), .done(dn[1]),
    .result(res[1]));

  wwm_projectile_ctrl #(.TICK_DIV(TD), .MAX_TICKS(8)) u_to (
    .clk(clk), .Reset(Reset), .start(st[2]), .Ack(Ack),
    .vX(vX), .vY(vY),
    .projectileCenterX(px[2]), .projectileCenterY(py[2]),
    .active(act[2]), .busy(bsy[2]), .done(dn[2]),
    .result(res[2]));

  wwm_projectile_ctrl #(.TICK_DIV(TD), .Y0(20)) u_high (
    .clk(clk), .Reset(Reset), .start(st[3]), .Ack(Ack),
    .vX(vX), .vY(vY),
    .projectileCenterX(px[3]), .projectileCenterY(py[3]),
    .active(act[3]), .busy(bsy[3]), .done(dn[3]),
    .result(res[3]));

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input int exp);
    total++;
    assert (obs === 32'(exp)) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Height after n ticks: launch minus the arithmetic series of velocities.
  // Velocity floor (-128) is never reached before the ground at these speeds.
  function automatic int ypos(input int y0, input int vy, input int n);
    return y0 - (vy * n - (n * (n - 1)) / 2);
  endfunction

  task automatic fly(input int d, input int vx, input int vy,
                     input bit poke,
                     output int rx, output int ry, output int rr);
    int x, y, n, r;
    bit fin;
    @(negedge clk);
    vX = 4'(vx);
    vY = 4'(vy);
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
    vX = 4'($urandom);
    vY = 4'($urandom);
    chk("launch_busy", bsy[d], 1);
    chk("launch_done", dn[d], 0);
    chk("launch_x", px[d], X0);
    chk("launch_y", py[d], y0_a[d]);
    chk("launch_res", res[d], 0);
    chk("launch_act", act[d], 1);
    n = 0;
    fin = 1'b0;
    r = 0;
    x = X0;
    y = y0_a[d];
    while (!fin && n < 1100) begin
      for (int c = 0; c < TD; c++) begin
        st[d] = (poke && n == 2 && c == 1);
        @(negedge clk);
      end
      st[d] = 1'b0;
      n++;
      x = X0 + vx * n;
      y = ypos(y0_a[d], vy, n);
      r = 0;
      if (y >= YG) begin
        r = 1;
        y = YG;
        if (x > xmax_a[d]) x = xmax_a[d];
      end else if (x > xmax_a[d]) begin
        r = 2;
        x = xmax_a[d];
      end else if (n == maxt_a[d]) begin
        r = 3;
      end
      fin = (r != 0);
      chk("tick_x", px[d], x);
      chk("tick_y", py[d], (y < 0) ? 0 : y);
      chk("tick_done", dn[d], int'(fin));
      chk("tick_act", act[d], int'(fin || y >= 0));
      if (fin) chk("end_result", res[d], r);
    end
    if (!fin) chk("flight_bound", dn[d], 1);
    rx = x;
    ry = y;
    rr = r;
  endtask

  task automatic ack(input int d, input int rx, input int ry,
                     input int rr, input bit with_start);
    int hold;
    hold = int'($urandom_range(0, 3));
    for (int i = 0; i < hold; i++) begin
      st[d] = 1'(i % 2);
      @(negedge clk);
      chk("hold_done", dn[d], 1);
      chk("hold_x", px[d], rx);
      chk("hold_y", py[d], (ry < 0) ? 0 : ry);
      chk("hold_res", res[d], rr);
    end
    st[d] = with_start;
    Ack = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
    Ack = 1'b0;
    chk("ack_done", dn[d], 0);
    chk("ack_busy", bsy[d], 0);
    chk("ack_act", act[d], 0);
    chk("ack_res", res[d], rr);
    @(negedge clk);
    chk("idle_busy", bsy[d], 0);
  endtask

  initial begin
    int rx, ry, rr;
    for (int i = 0; i < 4; i++) st[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_busy", bsy[i], 0);
      chk("rst_done", dn[i], 0);
      chk("rst_act", act[i], 0);
      chk("rst_res", res[i], 0);
      chk("rst_x", px[i], X0);
      chk("rst_y", py[i], y0_a[i]);
    end
    Reset = 1'b0;

    // reset in the middle of a flight, three ticks in
    @(negedge clk);
    vX = 4'd5;
    vY = 4'd10;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3 * TD) @(negedge clk);
    chk("mid_busy", bsy[0], 1);
    #2 Reset = 1'b1;
    #1;
    chk("mr_busy", bsy[0], 0);
    chk("mr_x", px[0], X0);
    chk("mr_y", py[0], 400);
    chk("mr_act", act[0], 0);
    @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    chk("mr_idle", bsy[0], 0);

    fly(0, 3, 0, 1'b0, rx, ry, rr);
    chk("t2_x", px[0], 130);
    chk("t2_y", py[0], 440);
    chk("t2_res", res[0], 1);
    ack(0, rx, ry, rr, 1'b0);

    fly(1, 15, 15, 1'b0, rx, ry, rr);
    chk("t3_x", px[1], 200);
    chk("t3_y", py[1], 316);
    chk("t3_res", res[1], 2);
    ack(1, rx, ry, rr, 1'b0);

    fly(2, 1, 15, 1'b0, rx, ry, rr);
    chk("t4_x", px[2], 108);
    chk("t4_res", res[2], 3);
    ack(2, rx, ry, rr, 1'b0);

    fly(0, 15, 15, 1'b0, rx, ry, rr);
    chk("t5_x", px[0], 610);
    chk("t5_y", py[0], 440);
    ack(0, rx, ry, rr, 1'b0);

    fly(3, 2, 15, 1'b0, rx, ry, rr);
    ack(3, rx, ry, rr, 1'b0);

    // stray starts in flight/done, then start with Ack must not relaunch
    fly(0, 7, 9, 1'b1, rx, ry, rr);
    ack(0, rx, ry, rr, 1'b1);
    fly(0, 4, 6, 1'b0, rx, ry, rr);
    ack(0, rx, ry, rr, 1'b0);

    for (int k = 0; k < 16; k++) begin
      int d;
      d = int'($urandom_range(0, 3));
      fly(d, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
          1'($urandom), rx, ry, rr);
      ack(d, rx, ry, rr, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
